reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised reset generator for one clock domain. It releases a vector of active-low resets in a fixed order with programmable spacing. The block has three parts: an async-assert/sync-deassert chain of configurable depth, a minimum-assertion stretch counter, and a staged release FSM. It also accepts a synchronous software reset request. It sits at the top of the SoC and drives the per-subsystem resets: interconnect, CPU, peripherals (I2C/UART), and the accelerator.

Parameters:
NUM_RST, 4, number of output reset channels; legal range is 1 or more.
SYNC_STAGES, 2, depth of the deassertion synchronizer chain; legal range is 2 or more.
MIN_ASSERT_CYC, 16, qualifying cycles all outputs stay asserted before the first release; legal range is 1 or more.
STAGE_DLY_CYC, 8, cycles between consecutive channel releases; legal range is 1 or more.
Illegal values cause an elaboration failure. The counter width is derived internally from max(MIN_ASSERT_CYC, STAGE_DLY_CYC).

Ports:
clk_i  input  1  single clock; everything is clocked on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
sw_rst_i  input  1  synchronous, active-high software reset request; must already be in the clk_i domain.
rst_no  output  NUM_RST  active-low resets; bit 0 is released first.
done_o  output  1  high when all channels are released.
stage_o  output  clog2(NUM_RST+1)  number of channels currently released.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values while rst_i=1, applied immediately without a clock:
  - synchronizer chain all 0
  - rst_no all 0
  - done_o=0, stage_o=0
  - counter 0, FSM in HOLD
- A rst_i pulse shorter than one clock period still produces a full reset.
- Synchronizer: a SYNC_STAGES-flop chain, shifting in 1 after rst_i falls. Its output (sync_ok) goes high at rising edge number SYNC_STAGES after the deassertion (the first edge after the fall is edge 1).
- FSM states:
  - HOLD: all outputs asserted; the counter runs on qualifying edges (sync_ok=1 and sw_rst_i=0).
  - HOLD exits to RELEASE when MIN_ASSERT_CYC qualifying edges have been counted. On that edge, rst_no[0] goes to 1, stage_o goes to 1, and the counter clears.
  - RELEASE: the counter increments every edge. When it reaches STAGE_DLY_CYC, the next channel k is released, stage_o increments, and the counter clears.
  - When the final channel (NUM_RST-1) is released, the FSM moves to DONE and done_o goes to 1 on that same edge.
  - DONE: outputs are static; the counter is idle.
- Async timing: rst_no[k] rises at edge SYNC_STAGES + MIN_ASSERT_CYC + k*STAGE_DLY_CYC after rst_i falls. With defaults: 18, 26, 34, 42.
- Release order is monotonic: rst_no is always a thermometer code of the form 0...01...1. No channel is ever released before a lower-indexed channel.
- Software reset:
  - sw_rst_i=1 sampled at any edge, in any state: at that edge rst_no goes to all 0, done_o and stage_o go to 0, the counter clears, and the FSM enters HOLD.
  - While sw_rst_i stays high, the counter is held at 0.
  - If the last high sample is at edge E, rst_no[0] rises at E+MIN_ASSERT_CYC and rst_no[k] at E+MIN_ASSERT_CYC+k*STAGE_DLY_CYC.
- sw_rst_i pulse of one cycle: produces the full stretched sequence.
- sw_rst_i asserted mid-RELEASE: already-released channels re-assert on the same edge, then the sequence restarts from channel 0.
- sw_rst_i while rst_i=1: no effect; the async reset dominates.
- rst_i reasserted mid-sequence: all state clears immediately. The next deassertion restarts the full timing, including the synchronizer latency.
- rst_i deasserting while sw_rst_i=1: the chain still syncs, but HOLD does not count until sw_rst_i is low.
- NUM_RST=1: the HOLD exit edge sets rst_no[0], stage_o=1 and done_o=1 simultaneously.
- All outputs are driven directly from flops: no glitches, no combinational paths from inputs to outputs.

Test Plan:
1. Defaults: assert rst_i for 3 cycles, then deassert mid-cycle. Required: rst_no=4'b0000 until edge 17; rst_no[0] rises at edge 18, then 0011@26, 0111@34, 1111@42; done_o rises at 42; stage_o steps 1,2,3,4.
2. Async assert: in DONE, pulse rst_i for half a period between edges. Required: rst_no=0, done_o=0, stage_o=0 immediately without a clock edge; the full 18/26/34/42 sequence repeats after release.
3. Software reset mid-release: at stage_o=2, drive sw_rst_i=1 for 1 cycle at edge E. Required: rst_no=0000 at E, then 0001@E+16, 0011@E+24, 0111@E+32, 1111@E+40.
4. Held software reset: hold sw_rst_i high for 50 cycles. Required: outputs stay 0 for the whole period; the release timing counts from the last high sample.
5. Parameter sweep with NUM_RST=1, SYNC_STAGES=3, MIN_ASSERT_CYC=1, STAGE_DLY_CYC=1. Required: rst_no[0], done_o and stage_o=1 all rise at edge 4 after rst_i falls.
6. Random rst_i/sw_rst_i stimulus with a checker. Required: rst_no is always a thermometer code; done_o=1 exactly when rst_no is all-ones; stage_o equals popcount(rst_no).

Source files
------------

// File: rtl/reset_sequencer.sv
// Purpose : staged reset generator; releases NUM_RST active-low resets in index order.
// Latency : rst_no[k] rises SYNC_STAGES + MIN_ASSERT_CYC + k*STAGE_DLY_CYC edges after rst_i falls.
// Backpressure: none; free-running once out of reset, restarted by sw_rst_i or rst_i.
//
// Ports:
//   clk_i    - single clock, rising edge
//   rst_i    - asynchronous active-high reset (assert async, deassert synchronised)
//   sw_rst_i - synchronous active-high software reset request (clk_i domain)
//   rst_no   - active-low resets, always a thermometer code, bit 0 released first
//   done_o   - high once every channel is released
//   stage_o  - number of channels currently released
module reset_sequencer #(
  parameter int NUM_RST        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_ASSERT_CYC = 16,
  parameter int STAGE_DLY_CYC  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sw_rst_i,
  output logic [NUM_RST-1:0]           rst_no,
  output logic                         done_o,
  output logic [$clog2(NUM_RST+1)-1:0] stage_o
);

  localparam int SW      = $clog2(NUM_RST + 1);
  localparam int CNT_MAX = (MIN_ASSERT_CYC > STAGE_DLY_CYC) ? MIN_ASSERT_CYC : STAGE_DLY_CYC;
  // Counter only ever holds 0 .. CNT_MAX-1 before it clears.
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  if (NUM_RST < 1 || SYNC_STAGES < 2 || MIN_ASSERT_CYC < 1 || STAGE_DLY_CYC < 1) begin : g_bad_param
    $error("reset_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    DONE
  } state_t;

  // Deassertion synchroniser: clears asynchronously, fills with ones after rst_i falls.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_ok;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign sync_ok = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_RST-1:0] rst_no_q;
  logic               done_q;
  logic [SW-1:0]      stage_q;

  // Values taken when the next channel is released.
  logic [NUM_RST-1:0] rst_no_d;
  logic [SW-1:0]      stage_d;
  logic               last_ch;

  assign rst_no_d = (rst_no_q << 1) | NUM_RST'(1);
  assign stage_d  = stage_q + SW'(1);
  assign last_ch  = (stage_q == SW'(NUM_RST - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      rst_no_q <= '0;
      done_q   <= 1'b0;
      stage_q  <= '0;
    end else if (sw_rst_i) begin
      // Software reset wins in every state and keeps the stretch counter at zero.
      state_q  <= HOLD;
      cnt_q    <= '0;
      rst_no_q <= '0;
      done_q   <= 1'b0;
      stage_q  <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          // Only edges after the synchroniser has settled count towards the stretch.
          if (sync_ok) begin
            if (cnt_q == CW'(MIN_ASSERT_CYC - 1)) begin
              cnt_q    <= '0;
              rst_no_q <= rst_no_d;
              stage_q  <= stage_d;
              if (last_ch) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= RELEASE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        RELEASE: begin
          if (cnt_q == CW'(STAGE_DLY_CYC - 1)) begin
            cnt_q    <= '0;
            rst_no_q <= rst_no_d;
            stage_q  <= stage_d;
            if (last_ch) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          cnt_q <= '0;
        end
        default: begin
          state_q <= HOLD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rst_no  = rst_no_q;
  assign done_o  = done_q;
  assign stage_o = stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose : self-checking bench for reset_sequencer, default and minimal parameter sets.
// Latency : n/a
// Backpressure: n/a
module tb_reset_sequencer;

  localparam int NA = 4, SA = 2, MA = 16, DA = 8;
  localparam int NB = 1, SB = 3, MB = 1, DB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;

  logic [NA-1:0] rst_n_a;
  logic          done_a;
  logic [2:0]    stage_a;
  logic [NB-1:0] rst_n_b;
  logic          done_b;
  logic [0:0]    stage_b;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_RST(NA), .SYNC_STAGES(SA), .MIN_ASSERT_CYC(MA), .STAGE_DLY_CYC(DA)) dut_a (
    .clk_i(clk), .rst_i(rst), .sw_rst_i(sw),
    .rst_no(rst_n_a), .done_o(done_a), .stage_o(stage_a)
  );

  reset_sequencer #(.NUM_RST(NB), .SYNC_STAGES(SB), .MIN_ASSERT_CYC(MB), .STAGE_DLY_CYC(DB)) dut_b (
    .clk_i(clk), .rst_i(rst), .sw_rst_i(sw),
    .rst_no(rst_n_b), .done_o(done_b), .stage_o(stage_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: edges since rst_i fell, and qualifying edges since the last clear.
  int m_since = 0;
  int m_qa    = 0;
  int m_qb    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_since = 0;
      m_qa    = 0;
      m_qb    = 0;
    end else begin
      if (sw) begin
        m_qa = 0;
        m_qb = 0;
      end else begin
        if (m_since >= SA && m_qa < 100000) m_qa++;
        if (m_since >= SB && m_qb < 100000) m_qb++;
      end
      if (m_since < 100000) m_since++;
    end
  end

  // Channels released after q qualifying edges.
  function automatic int stage_of(int q, int m, int d, int n);
    int s;
    if (q < m) return 0;
    s = 1 + (q - m) / d;
    return (s > n) ? n : s;
  endfunction

  // Channels released at edge e counted from a reference point, first release at edge 'first'.
  function automatic int spec_stage(int e, int first, int d, int n);
    int s;
    s = 0;
    for (int k = 0; k < n; k++) if (e >= first + k * d) s++;
    return s;
  endfunction

  function automatic logic [7:0] exp_a(int st);
    logic [NA-1:0] r;
    r = NA'((1 << st) - 1);
    return {r, (st == NA), 3'(st)};
  endfunction

  function automatic logic [2:0] exp_b(int st);
    return {1'(st), (st == NB), 1'(st)};
  endfunction

  task automatic test_reset();
    logic [7:0] act;
    rst = 1'b1;
    sw  = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      act = {rst_n_a, done_a, stage_a};
      n_vec++;
      if (act !== exp_a(0)) begin
        n_err++;
        $display("FAIL reset_hold: got %b want %b", act, exp_a(0));
      end
    end
    @(negedge clk) rst = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      act = {rst_n_a, done_a, stage_a};
      n_vec++;
      if (act !== exp_a(spec_stage(e, SA + MA, DA, NA))) begin
        n_err++;
        $display("FAIL release_seq edge %0d: got %b want %b", e, act, exp_a(spec_stage(e, SA + MA, DA, NA)));
      end
      n_vec++;
      if (act !== exp_a(stage_of(m_qa, MA, DA, NA))) begin
        n_err++;
        $display("FAIL release_model edge %0d: got %b want %b", e, act, exp_a(stage_of(m_qa, MA, DA, NA)));
      end
    end
  endtask

  task automatic test_async_assert();
    logic [7:0] act;
    @(posedge clk);
    #2 rst = 1'b1;
    #2;
    act = {rst_n_a, done_a, stage_a};
    n_vec++;
    if (act !== exp_a(0)) begin
      n_err++;
      $display("FAIL async_assert: got %b want %b", act, exp_a(0));
    end
    #3 rst = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      act = {rst_n_a, done_a, stage_a};
      n_vec++;
      if (act !== exp_a(spec_stage(e, SA + MA, DA, NA))) begin
        n_err++;
        $display("FAIL async_rerelease edge %0d: got %b want %b", e, act, exp_a(spec_stage(e, SA + MA, DA, NA)));
      end
    end
  endtask

  task automatic test_sw_mid_release();
    logic [7:0] act;
    bit found;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (stage_a == 3'd2) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL sw_mid_wait: got stage %0d want 2 within 100 cycles", stage_a);
      return;
    end
    sw = 1'b1;
    @(posedge clk); #1;
    act = {rst_n_a, done_a, stage_a};
    n_vec++;
    if (act !== exp_a(0)) begin
      n_err++;
      $display("FAIL sw_mid_clear: got %b want %b", act, exp_a(0));
    end
    @(negedge clk) sw = 1'b0;
    for (int e = 1; e <= 42; e++) begin
      @(posedge clk); #1;
      act = {rst_n_a, done_a, stage_a};
      n_vec++;
      if (act !== exp_a(spec_stage(e, MA, DA, NA))) begin
        n_err++;
        $display("FAIL sw_mid_seq E+%0d: got %b want %b", e, act, exp_a(spec_stage(e, MA, DA, NA)));
      end
    end
  endtask

  task automatic test_sw_held();
    logic [7:0] act;
    logic [2:0] actb;
    @(negedge clk) sw = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      act  = {rst_n_a, done_a, stage_a};
      actb = {rst_n_b, done_b, stage_b};
      n_vec++;
      if (act !== exp_a(0) || actb !== exp_b(0)) begin
        n_err++;
        $display("FAIL sw_held cycle %0d: got %b/%b want %b/%b", i, act, actb, exp_a(0), exp_b(0));
      end
    end
    @(negedge clk) sw = 1'b0;
    for (int e = 1; e <= 42; e++) begin
      @(posedge clk); #1;
      act = {rst_n_a, done_a, stage_a};
      n_vec++;
      if (act !== exp_a(spec_stage(e, MA, DA, NA))) begin
        n_err++;
        $display("FAIL sw_held_seq E+%0d: got %b want %b", e, act, exp_a(spec_stage(e, MA, DA, NA)));
      end
    end
  endtask

  task automatic test_min_params();
    logic [2:0] actb;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      actb = {rst_n_b, done_b, stage_b};
      n_vec++;
      if (actb !== exp_b((e >= 4) ? 1 : 0)) begin
        n_err++;
        $display("FAIL min_params edge %0d: got %b want %b", e, actb, exp_b((e >= 4) ? 1 : 0));
      end
      n_vec++;
      if (actb !== exp_b(stage_of(m_qb, MB, DB, NB))) begin
        n_err++;
        $display("FAIL min_params_model edge %0d: got %b want %b", e, actb, exp_b(stage_of(m_qb, MB, DB, NB)));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] act;
    logic [2:0] actb;
    logic [4:0] wide;
    int r;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      act  = {rst_n_a, done_a, stage_a};
      actb = {rst_n_b, done_b, stage_b};
      n_vec++;
      if (act !== exp_a(stage_of(m_qa, MA, DA, NA))) begin
        n_err++;
        $display("FAIL rand_model_a cycle %0d: got %b want %b", i, act, exp_a(stage_of(m_qa, MA, DA, NA)));
      end
      n_vec++;
      if (actb !== exp_b(stage_of(m_qb, MB, DB, NB))) begin
        n_err++;
        $display("FAIL rand_model_b cycle %0d: got %b want %b", i, actb, exp_b(stage_of(m_qb, MB, DB, NB)));
      end
      wide = {1'b0, rst_n_a} + 5'd1;
      n_vec++;
      if ((wide[3:0] & rst_n_a) !== 4'd0 || done_a !== (&rst_n_a) ||
          32'(stage_a) !== $countones(rst_n_a)) begin
        n_err++;
        $display("FAIL rand_invariant cycle %0d: got rst_no %b done %b stage %0d want thermometer/all-ones/popcount",
                 i, rst_n_a, done_a, stage_a);
      end
      r = $urandom_range(0, 999);
      if (r >= 995) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end else if (r < 8) begin
        sw = 1'b1;
      end else if (r < 500) begin
        sw = 1'b0;
      end
    end
    sw = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_async_assert();
    test_sw_mid_release();
    test_sw_held();
    test_min_params();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
